// File: rtl/uart_rx_servo_cmd.sv
// 8N1 UART receiver that holds the last valid byte as a servo position.
// Define UART_RX_PARITY_EN to receive 8E1 frames instead (even parity checked).
module uart_rx_servo_cmd #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter logic [7:0]  RESET_DATA = 8'h80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       frame_err,
    output logic       busy
);
    localparam int unsigned DIV    = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned M      = OVERSAMPLE / 2;
    localparam int          DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int          TICK_W = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TICK_W-1:0] CNT_SAMP0 = TICK_W'(M - 1);
    localparam logic [TICK_W-1:0] CNT_SAMP1 = TICK_W'(M);
    localparam logic [TICK_W-1:0] CNT_DEC   = TICK_W'(M + 1);
    localparam logic [TICK_W-1:0] CNT_LAST  = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_sync;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [TICK_W-1:0]  r_tick_cnt;
    logic [2:0]         r_bit_cnt;
    logic               r_samp0;
    logic               r_samp1;
    logic [7:0]         r_shift;
    logic [7:0]         r_data;
    logic               r_ready;
    logic               r_ferr;
    logic               w_rxs;
    logic               w_counting;
    logic               w_tick;
    logic               w_decide;
    logic               w_bit_end;
    logic               w_maj;
    logic               w_par_ok;
    logic               w_ready_next;
    logic               w_ferr_next;

    assign w_rxs      = r_sync[1];
    assign w_counting = (r_state == S_START) || (r_state == S_DATA) ||
                        (r_state == S_PARITY) || (r_state == S_STOP);
    assign w_tick     = w_counting && (r_div_cnt == DIV_LAST);
    assign w_decide   = w_tick && (r_tick_cnt == CNT_DEC);
    assign w_bit_end  = w_tick && (r_tick_cnt == CNT_LAST);
    // Third vote is the live sample taken at the decision tick.
    assign w_maj      = (r_samp0 & r_samp1) | (r_samp0 & w_rxs) | (r_samp1 & w_rxs);

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bit <= 1'b0;
        end else if ((r_state == S_PARITY) && w_decide) begin
            r_par_bit <= w_maj;
        end
    end

    assign w_par_ok = ~(^{r_shift, r_par_bit});
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RxD};
        end
    end

    // Counters sit at zero outside a frame so the bit phase starts at the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (!w_counting) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_tick) begin
                r_tick_cnt <= (r_tick_cnt == CNT_LAST) ? '0 : r_tick_cnt + 1'b1;
            end
            if ((r_state == S_DATA) && w_bit_end) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp0 <= 1'b1;
            r_samp1 <= 1'b1;
            r_shift <= '0;
        end else begin
            if (w_tick && (r_tick_cnt == CNT_SAMP0)) begin
                r_samp0 <= w_rxs;
            end
            if (w_tick && (r_tick_cnt == CNT_SAMP1)) begin
                r_samp1 <= w_rxs;
            end
            if ((r_state == S_DATA) && w_decide) begin
                r_shift <= {w_maj, r_shift[7:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_decide && w_maj) begin
                    w_state_next = S_IDLE;
                end else if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            // Leave at the stop decision so a following start edge is never missed.
            S_STOP: begin
                if (w_decide) begin
                    w_state_next = w_maj ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (w_rxs) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state != S_IDLE);
        w_ready_next = 1'b0;
        w_ferr_next  = 1'b0;
        if ((r_state == S_STOP) && w_decide) begin
            if (w_maj && w_par_ok) begin
                w_ready_next = 1'b1;
            end else begin
                w_ferr_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= RESET_DATA;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_ready <= w_ready_next;
            r_ferr  <= w_ferr_next;
            if (w_ready_next) begin
                r_data <= r_shift;
            end
        end
    end

    assign RxD_data       = r_data;
    assign RxD_data_ready = r_ready;
    assign frame_err      = r_ferr;

endmodule

// File: tb/tb_uart_rx_servo_cmd.sv
// Directed bench for uart_rx_servo_cmd: a frame-level model predicts each
// ready/frame_err pulse (kind, byte, nominal cycle) and the held output byte.
`timescale 1ns/1ps
module tb_uart_rx_servo_cmd;
    localparam int CLK_HZ  = 50000000;
    localparam int BAUD    = 115200;
    localparam int OS      = 16;
    localparam int DIV     = CLK_HZ / (BAUD * OS);
    localparam int M       = OS / 2;
    localparam int BIT_CLK = DIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Falling edge to pulse: all bits before the stop bit, plus M+2 ticks, plus sync.
    localparam int LAT = ((9 + PAR_BITS) * OS + M + 2) * DIV + 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       RxD   = 1'b1;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       frame_err;
    logic       busy;

    uart_rx_servo_cmd #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS),
        .RESET_DATA(8'h80)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .RxD           (RxD),
        .RxD_data      (RxD_data),
        .RxD_data_ready(RxD_data_ready),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit         is_ready;
        logic [7:0] data;
        int         t;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] exp_held = 8'h80;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         last_ready_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Per-cycle compare against the frame-level model.
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            exp_held = 8'h80;
            exp_q.delete();
            check("rst_data", RxD_data, 8'h80);
            check("rst_ready", RxD_data_ready, 0);
            check("rst_ferr", frame_err, 0);
            check("rst_busy", busy, 0);
        end else begin
            if (RxD_data_ready && frame_err) begin
                check("ready_ferr_overlap", 1, 0);
            end
            if (RxD_data_ready || frame_err) begin
                if (exp_q.size() == 0) begin
                    check(frame_err ? "spurious_ferr" : "spurious_ready",
                          {RxD_data_ready, frame_err}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind_ready", RxD_data_ready, e.is_ready);
                    check("pulse_time_in_window",
                          (cyc >= e.t - DIV) && (cyc <= e.t + DIV), 1);
                    if (e.is_ready) exp_held = e.data;
                end
                if (RxD_data_ready) last_ready_cyc = cyc;
            end else if (exp_q.size() != 0 && cyc > exp_q[0].t + DIV) begin
                check("pulse_missing", RxD_data_ready | frame_err, 1);
                void'(exp_q.pop_front());
            end
            check("held_data", RxD_data, exp_held);
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        ev_t e;
        logic ok;
        ok = stop_b;
        if (PAR_BITS != 0) ok = ok && ((^d ^ par_b) == 1'b0);
        e.is_ready = ok;
        e.data     = d;
        e.t        = cyc + LAT;
        exp_q.push_back(e);
        RxD = 1'b0;
        wait_clks(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            wait_clks(BIT_CLK / 2);
            check($sformatf("busy_mid_bit%0d_%02h", i, d), busy, 1);
            wait_clks(BIT_CLK - BIT_CLK / 2);
        end
        if (PAR_BITS != 0) begin
            RxD = par_b;
            wait_clks(BIT_CLK);
        end
        RxD = stop_b;
        wait_clks(BIT_CLK);
        $display("frame %02h stop=%0b par=%0b -> expect %s", d, stop_b, par_b,
                 ok ? "ready" : "frame_err");
    endtask

    initial begin
        int t0;
        logic [7:0] c3;
        c3 = 8'hC3;
        #1 rst_n = 1'b0;
        wait_clks(5);
        check("reset_data_lit", RxD_data, 8'h80);
        check("reset_busy_lit", busy, 0);
        rst_n = 1'b1;
        wait_clks(20);

        // 100-clock glitch: no frame, receiver returns idle
        RxD = 1'b0;
        wait_clks(100);
        RxD = 1'b1;
        wait_clks(9 * DIV + 3);
        check("glitch_busy", busy, 0);
        check("glitch_data_lit", RxD_data, 8'h80);
        $display("glitch 100 clk -> expect no pulse");
        wait_clks(BIT_CLK);

        t0 = cyc;
        drive_frame(8'h5A, 1'b1, 1'b0);
        check("lat_5a_window", (last_ready_cyc - t0 >= 4134) && (last_ready_cyc - t0 <= 4188), 1);
        check("data_5a_lit", RxD_data, 8'h5A);
        wait_clks(BIT_CLK);

        drive_frame(8'h33, 1'b0, 1'b0);
        RxD = 1'b1;
        wait_clks(2 * BIT_CLK);
        check("ferr_keep_lit", RxD_data, 8'h5A);
        check("ferr_idle_busy", busy, 0);

        drive_frame(8'h44, 1'b1, 1'b0);
        check("data_44_lit", RxD_data, 8'h44);
        wait_clks(BIT_CLK);

        drive_frame(8'h00, 1'b1, 1'b0);
        check("b2b_first_lit", RxD_data, 8'h00);
        drive_frame(8'hFF, 1'b1, 1'b0);
        check("b2b_second_lit", RxD_data, 8'hFF);
        wait_clks(BIT_CLK);

        // 0xC3 aborted by reset half-way through bit 4
        RxD = 1'b0;
        wait_clks(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            RxD = c3[i];
            wait_clks(BIT_CLK);
        end
        RxD = c3[4];
        wait_clks(BIT_CLK / 2);
        check("c3_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        RxD   = 1'b1;
        wait_clks(10);
        check("c3_rst_data_lit", RxD_data, 8'h80);
        rst_n = 1'b1;
        $display("frame c3 aborted by reset -> expect no pulse");
        wait_clks(2 * BIT_CLK);
        check("after_rst_busy", busy, 0);
        drive_frame(8'h21, 1'b1, 1'b0);
        check("data_21_lit", RxD_data, 8'h21);
        wait_clks(BIT_CLK);

`ifdef UART_RX_PARITY_EN
        drive_frame(8'h07, 1'b1, 1'b1);
        check("par_ok_lit", RxD_data, 8'h07);
        wait_clks(BIT_CLK);
        drive_frame(8'h55, 1'b1, 1'b1);
        check("par_bad_keep_lit", RxD_data, 8'h07);
        wait_clks(BIT_CLK);
        drive_frame(8'h07, 1'b1, 1'b0);
        check("par_bad07_keep_lit", RxD_data, 8'h07);
        wait_clks(BIT_CLK);
`endif

        wait_clks(BIT_CLK);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
